// File: rtl/frame_sync_pkg.sv
// Shared definitions for the 193-bit frame-alignment controller: state encoding
// and default link parameters.
package frame_sync_pkg;

   localparam int unsigned FRAME_LEN_DEF = 193;
   localparam int unsigned SYNC_W_DEF    = 4;
   localparam logic [SYNC_W_DEF-1:0] SYNC_WORD_DEF = 4'b1001;

   localparam logic [1:0] ST_HUNT    = 2'b00;
   localparam logic [1:0] ST_PRESYNC = 2'b01;
   localparam logic [1:0] ST_SYNC    = 2'b10;

   typedef enum logic [1:0] {
      StHunt    = ST_HUNT,
      StPresync = ST_PRESYNC,
      StSync    = ST_SYNC
   } state_e;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sync_word_det.sv
// Sync-word shift register; hit compares the stored history plus the bit
// currently on the input against the sync word.
module sync_word_det
   import frame_sync_pkg::*;
#(
   parameter int unsigned             SYNC_W    = SYNC_W_DEF,
   parameter logic [SYNC_W-1:0]       SYNC_WORD = SYNC_WORD_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic in,
   input  logic in_valid,
   output logic hit
);

   // The oldest bit shifts out before it is ever compared, so only SYNC_W-1
   // bits of history need storage.
   logic [SYNC_W-2:0] sr_q;
   logic [SYNC_W-1:0] sr_next;

   assign sr_next = {sr_q, in};
   assign hit     = (sr_next == SYNC_WORD);

   always_ff @(posedge clk) begin
      if (reset) begin
         sr_q <= '0;
      end else if (in_valid) begin
         sr_q <= sr_next[SYNC_W-2:0];
      end
   end

endmodule

// File: rtl/frame_sync_ctrl.sv
// Frame-alignment controller: HUNT/PRESYNC/SYNC FSM, frame bit counter and
// registered status pulses. Define SYNC_STATS_EN to add miss/loss totals.
module frame_sync_ctrl
   import frame_sync_pkg::*;
#(
   parameter int unsigned       FRAME_LEN = FRAME_LEN_DEF,
   parameter int unsigned       SYNC_W    = SYNC_W_DEF,
   parameter logic [SYNC_W-1:0] SYNC_WORD = SYNC_WORD_DEF,
   parameter int unsigned       CONFIRM_N = 3,
   parameter int unsigned       LOSS_M    = 2,
   parameter int unsigned       CNT_W     = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in,
   input  logic             in_valid,
   output logic [CNT_W-1:0] bit_cnt,
   output logic [1:0]       state,
   output logic             in_sync,
   output logic             frame,
   output logic             sync_err,
   output logic             los
`ifdef SYNC_STATS_EN
   ,
   output logic [15:0]      miss_total,
   output logic [7:0]       los_total
`endif
);

   localparam int unsigned      HM_W      = $clog2(max_u(CONFIRM_N, LOSS_M) + 1);
   localparam logic [HM_W-1:0]  CONFIRM_C = HM_W'(CONFIRM_N);
   localparam logic [HM_W-1:0]  LOSS_C    = HM_W'(LOSS_M);
   localparam logic [HM_W-1:0]  HM_MAX    = '1;
   localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(FRAME_LEN - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [HM_W-1:0]  hits_q, hits_d, hits_inc;
   logic [HM_W-1:0]  miss_q, miss_d, miss_inc;
   logic             frame_q, frame_d;
   logic             sync_err_q, sync_err_d;
   logic             los_q, los_d;
   logic             hit;
   logic             ckpt;

   sync_word_det #(
      .SYNC_W    (SYNC_W),
      .SYNC_WORD (SYNC_WORD)
   ) u_det (
      .clk      (clk),
      .reset    (reset),
      .in       (in),
      .in_valid (in_valid),
      .hit      (hit)
   );

   assign ckpt     = in_valid & (bit_cnt_q == LAST_BIT);
   assign hits_inc = (hits_q == HM_MAX) ? hits_q : hits_q + HM_W'(1);
   assign miss_inc = (miss_q == HM_MAX) ? miss_q : miss_q + HM_W'(1);

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      hits_d     = hits_q;
      miss_d     = miss_q;
      frame_d    = 1'b0;
      sync_err_d = 1'b0;
      los_d      = 1'b0;
      if (in_valid) begin
         bit_cnt_d = ckpt ? '0 : bit_cnt_q + CNT_W'(1);
         case (state_q)
            StHunt: begin
               bit_cnt_d = '0;
               if (hit) begin
                  state_d = StPresync;
                  hits_d  = HM_W'(1);
               end
            end
            StPresync: begin
               // Hits between checkpoints are ignored; only aligned repeats count.
               if (ckpt) begin
                  if (hit) begin
                     hits_d = hits_inc;
                     if (hits_inc == CONFIRM_C) begin
                        state_d = StSync;
                        miss_d  = '0;
                        frame_d = 1'b1;
                     end
                  end else begin
                     state_d = StHunt;
                     hits_d  = '0;
                  end
               end
            end
            StSync: begin
               if (ckpt) begin
                  frame_d = 1'b1;
                  if (hit) begin
                     miss_d = '0;
                  end else begin
                     sync_err_d = 1'b1;
                     miss_d     = miss_inc;
                     if (miss_inc == LOSS_C) begin
                        state_d   = StHunt;
                        los_d     = 1'b1;
                        bit_cnt_d = '0;
                        hits_d    = '0;
                        miss_d    = '0;
                     end
                  end
               end
            end
            default: begin
               state_d   = StHunt;
               bit_cnt_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StHunt;
         bit_cnt_q  <= '0;
         hits_q     <= '0;
         miss_q     <= '0;
         frame_q    <= 1'b0;
         sync_err_q <= 1'b0;
         los_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         hits_q     <= hits_d;
         miss_q     <= miss_d;
         frame_q    <= frame_d;
         sync_err_q <= sync_err_d;
         los_q      <= los_d;
      end
   end

   assign bit_cnt  = bit_cnt_q;
   assign state    = state_q;
   assign in_sync  = (state_q == StSync);
   assign frame    = frame_q;
   assign sync_err = sync_err_q;
   assign los      = los_q;

`ifdef SYNC_STATS_EN
   logic [15:0] miss_total_q;
   logic [7:0]  los_total_q;

   // Totals advance on the same edge that registers the matching pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         miss_total_q <= '0;
         los_total_q  <= '0;
      end else begin
         if (sync_err_d && (miss_total_q != '1)) miss_total_q <= miss_total_q + 16'd1;
         if (los_d && (los_total_q != '1))       los_total_q  <= los_total_q + 8'd1;
      end
   end

   assign miss_total = miss_total_q;
   assign los_total  = los_total_q;
`endif

endmodule
